// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard detection: register-use stalls plus HI/LO busy interlock.
// Optional stall-cycle counter output enabled by defining HAZARD_STALL_CNT_EN.
module hazard_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  rs_D,
   input  logic [4:0]  rt_D,
   input  logic [1:0]  Tuse_rs_D,
   input  logic [1:0]  Tuse_rt_D,
   input  logic [4:0]  A_E,
   input  logic [1:0]  Tnew_E,
   input  logic [4:0]  A_M,
   input  logic [1:0]  Tnew_M,
   input  logic        md_start_E,
   input  logic        md_div_E,
   input  logic        md_use_D,
   output logic        stall,
   output logic        clr_E,
   output logic        md_busy
`ifdef HAZARD_STALL_CNT_EN
   ,
   output logic [31:0] stall_cnt
`endif
);

   logic [3:0] r_md_cnt;
   logic       w_stall_rs;
   logic       w_stall_rt;
   logic       w_stall_md;
   logic       w_busy_raw;
   logic       w_stall_raw;

   // A hazard exists only when the consumer needs the value before the producer can forward it.
   assign w_stall_rs = (rs_D != 5'd0) && (Tuse_rs_D != 2'd3) &&
                       (((A_E == rs_D) && (Tuse_rs_D < Tnew_E)) ||
                        ((A_M == rs_D) && (Tuse_rs_D < Tnew_M)));

   assign w_stall_rt = (rt_D != 5'd0) && (Tuse_rt_D != 2'd3) &&
                       (((A_E == rt_D) && (Tuse_rt_D < Tnew_E)) ||
                        ((A_M == rt_D) && (Tuse_rt_D < Tnew_M)));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_md_cnt <= 4'd0;
      end else if (md_start_E) begin
         r_md_cnt <= md_div_E ? 4'd10 : 4'd5;
      end else if (r_md_cnt != 4'd0) begin
         r_md_cnt <= r_md_cnt - 4'd1;
      end
   end

   assign w_busy_raw  = md_start_E || (r_md_cnt != 4'd0);
   assign w_stall_md  = md_use_D && w_busy_raw;
   assign w_stall_raw = w_stall_rs || w_stall_rt || w_stall_md;

   // Outputs are gated by reset so a held-low reset masks a live md_start_E.
   assign md_busy = reset && w_busy_raw;
   assign stall   = reset && w_stall_raw;
   assign clr_E   = stall;

`ifdef HAZARD_STALL_CNT_EN
   logic [31:0] r_stall_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stall_cnt <= 32'd0;
      end else if (stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed and randomized checks of hazard_ctrl against a behavioural model.
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] rs_D, rt_D, A_E, A_M;
   logic [1:0] Tuse_rs_D, Tuse_rt_D, Tnew_E, Tnew_M;
   logic       md_start_E, md_div_E, md_use_D;
   logic       stall, clr_E, md_busy;
`ifdef HAZARD_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif

   int n_cmp = 0;
   int n_err = 0;

   hazard_ctrl dut (
      .clk(clk), .reset(reset),
      .rs_D(rs_D), .rt_D(rt_D), .Tuse_rs_D(Tuse_rs_D), .Tuse_rt_D(Tuse_rt_D),
      .A_E(A_E), .Tnew_E(Tnew_E), .A_M(A_M), .Tnew_M(Tnew_M),
      .md_start_E(md_start_E), .md_div_E(md_div_E), .md_use_D(md_use_D),
      .stall(stall), .clr_E(clr_E), .md_busy(md_busy)
`ifdef HAZARD_STALL_CNT_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Model: remember when the last mult/div started and how long it lasts.
   int     cyc = 0;
   int     last_start = 0;
   int     last_lat = 0;
   bit     md_valid = 1'b0;
   longint m_stall_cnt = 0;

   function automatic bit reg_hz(input int src, input int tuse);
      if (src == 0 || tuse == 3) return 1'b0;
      return ((int'(A_E) == src) && (tuse < int'(Tnew_E))) ||
             ((int'(A_M) == src) && (tuse < int'(Tnew_M)));
   endfunction

   function automatic bit exp_busy();
      if (!reset) return 1'b0;
      return md_start_E || (md_valid && (cyc - last_start) <= last_lat);
   endfunction

   function automatic bit exp_stall();
      if (!reset) return 1'b0;
      return reg_hz(int'(rs_D), int'(Tuse_rs_D)) || reg_hz(int'(rt_D), int'(Tuse_rt_D)) ||
             (md_use_D && exp_busy());
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      if (reset && exp_stall() && m_stall_cnt != 64'hFFFF_FFFF) m_stall_cnt++;
      if (!reset) begin
         md_valid    = 1'b0;
         m_stall_cnt = 0;
      end else if (md_start_E) begin
         md_valid   = 1'b1;
         last_start = cyc;
         last_lat   = md_div_E ? 10 : 5;
      end
      cyc++;
   end

   always @(negedge clk) begin
      check("model_stall", stall, exp_stall());
      check("model_clr_E", clr_E, exp_stall());
      check("model_md_busy", md_busy, exp_busy());
`ifdef HAZARD_STALL_CNT_EN
      check("model_stall_cnt", stall_cnt, m_stall_cnt);
`endif
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rs_D = 0; rt_D = 0; A_E = 0; A_M = 0;
      Tuse_rs_D = 3; Tuse_rt_D = 3; Tnew_E = 0; Tnew_M = 0;
      md_start_E = 0; md_div_E = 0; md_use_D = 0;
   endtask

   task automatic count_md_stalls(input bit is_div, output int n, output bit busy_tracks);
      n = 0;
      busy_tracks = 1'b1;
      md_start_E = 1; md_div_E = is_div; md_use_D = 1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (stall) n++;
         if (md_busy != stall) busy_tracks = 1'b0;
         step();
         md_start_E = 0;
      end
   endtask

   int n;
   bit tracks;

   initial begin
      reset = 0;
      idle_inputs();
      md_start_E = 1;
      #2;
      check("reset_stall", stall, 0);
      check("reset_md_busy", md_busy, 0);
      check("reset_clr_E", clr_E, 0);
      step();
      md_start_E = 0;
      reset = 1;
      step();

      // Load-use then the producer moves to M.
      A_E = 5; Tnew_E = 2; rs_D = 5; Tuse_rs_D = 1;
      @(negedge clk);
      check("load_use_stall", stall, 1);
      check("load_use_clr_E", clr_E, 1);
      step();
      A_E = 0; Tnew_E = 0; A_M = 5; Tnew_M = 1;
      @(negedge clk);
      check("load_use_next", stall, 0);
      step();

      idle_inputs();
      A_E = 0; rs_D = 0; Tuse_rs_D = 0; Tnew_E = 2;
      @(negedge clk);
      check("zero_reg", stall, 0);
      step();

      idle_inputs();
      rt_D = 7; A_M = 7; Tuse_rt_D = 0; Tnew_M = 1;
      @(negedge clk);
      check("rt_hazard", stall, 1);
      step();

      idle_inputs();
      count_md_stalls(1'b0, n, tracks);
      check("mult_stalls", n, 6);
      idle_inputs();
      count_md_stalls(1'b1, n, tracks);
      check("div_stalls", n, 11);
      check("div_busy_eq_stall", tracks, 1);

      // Register and HI/LO hazard coincide, then clear.
      idle_inputs();
      md_start_E = 1; md_use_D = 1; rs_D = 3; A_E = 3; Tuse_rs_D = 0; Tnew_E = 1;
      @(negedge clk);
      check("coincide_stall", stall, 1);
      step();
      idle_inputs();
      for (int i = 0; i < 12; i++) step();

      // Reset mid-divide.
      md_start_E = 1; md_div_E = 1; md_use_D = 1;
      step();
      md_start_E = 0;
      for (int i = 0; i < 3; i++) step();
      @(negedge clk);
      check("div_running", stall, 1);
      step();
      reset = 0; md_start_E = 1;
      #1;
      check("mid_reset_stall", stall, 0);
      check("mid_reset_busy", md_busy, 0);
      step();
      reset = 1; md_start_E = 0; md_use_D = 1;
      @(negedge clk);
      check("after_reset_stall", stall, 0);
      check("after_reset_busy", md_busy, 0);
      step();

      // Randomized traffic; the negedge process checks every cycle.
      for (int i = 0; i < 4000; i++) begin
         rs_D = 5'($urandom_range(0, 3)); rt_D = 5'($urandom_range(0, 3));
         A_E = 5'($urandom_range(0, 3));  A_M = 5'($urandom_range(0, 3));
         Tuse_rs_D = 2'($urandom); Tuse_rt_D = 2'($urandom);
         Tnew_E = 2'($urandom); Tnew_M = 2'($urandom);
         md_start_E = ($urandom_range(0, 9) == 0);
         md_div_E = 1'($urandom); md_use_D = 1'($urandom);
         reset = ($urandom_range(0, 299) != 0);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
